// File: rtl/clk_freq_monitor.sv
// Clock-frequency monitor: measures the period and high time of an asynchronous
// clock in system-clock cycles, with tolerance, lock, min/max and timeout status.
module clk_freq_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] tol,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             out_of_tol,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic             lock,
    output logic             timeout
);

    localparam int unsigned      LCW      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_CYC);
    localparam logic [LCW-1:0]   LOCK_VAL = LCW'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise_q, fall_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_hold_q, high_hold_d;
    logic             fall_seen_q, fall_seen_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             oot_q, oot_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             lock_q, lock_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [LCW-1:0]   lock_nxt;
    logic             timeout_q, timeout_d;
    logic [CNT_W:0]   diff;
    logic             in_tol;

    // Edges are registered once more so the FSM sees them on the 4th edge after
    // sig_in is first sampled high; s3_q is the level aligned with those edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= sig_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    always_comb begin
        if (cnt_q >= exp_period) begin
            diff = {1'b0, cnt_q} - {1'b0, exp_period};
        end else begin
            diff = {1'b0, exp_period} - {1'b0, cnt_q};
        end
        in_tol = (diff <= {1'b0, tol});
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hcnt_d       = hcnt_q;
        high_hold_d  = high_hold_q;
        fall_seen_d  = fall_seen_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        oot_d        = oot_q;
        min_d        = min_q;
        max_d        = max_q;
        lock_d       = lock_q;
        lock_cnt_d   = lock_cnt_q;
        timeout_d    = timeout_q;
        lock_nxt     = (lock_cnt_q >= LOCK_VAL) ? LOCK_VAL : lock_cnt_q + LCW'(1);

        if (!en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            hcnt_d      = '0;
            fall_seen_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d       = '0;
                    hcnt_d      = '0;
                    fall_seen_d = 1'b0;
                    state_d     = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    cnt_d  = '0;
                    hcnt_d = '0;
                    if (rise_q) begin
                        cnt_d       = CNT_ONE;
                        hcnt_d      = CNT_ONE;
                        fall_seen_d = 1'b0;
                        state_d     = MEASURE;
                    end
                end
                MEASURE: begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                    if (s3_q && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_ONE;
                    if (fall_q) begin
                        high_hold_d = hcnt_q;
                        fall_seen_d = 1'b1;
                    end
                    if (rise_q) begin
                        period_d     = cnt_q;
                        high_time_d  = fall_seen_q ? high_hold_q : cnt_q;
                        meas_valid_d = 1'b1;
                        oot_d        = ~in_tol;
                        if (cnt_q < min_q) min_d = cnt_q;
                        if (cnt_q > max_q) max_d = cnt_q;
                        if (in_tol) begin
                            lock_cnt_d = lock_nxt;
                            lock_d     = (lock_nxt == LOCK_VAL);
                        end else begin
                            lock_cnt_d = '0;
                            lock_d     = 1'b0;
                        end
                        cnt_d       = CNT_ONE;
                        hcnt_d      = CNT_ONE;
                        fall_seen_d = 1'b0;
                    end else if (cnt_q == TO_VAL) begin
                        timeout_d  = 1'b1;
                        lock_d     = 1'b0;
                        lock_cnt_d = '0;
                        state_d    = WAIT_FIRST;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // clear overrides any same-cycle measurement or timeout update
        if (clear) begin
            min_d      = '1;
            max_d      = '0;
            lock_d     = 1'b0;
            lock_cnt_d = '0;
            timeout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            high_hold_q  <= '0;
            fall_seen_q  <= 1'b0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            oot_q        <= 1'b0;
            min_q        <= '1;
            max_q        <= '0;
            lock_q       <= 1'b0;
            lock_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            high_hold_q  <= high_hold_d;
            fall_seen_q  <= fall_seen_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            oot_q        <= oot_d;
            min_q        <= min_d;
            max_q        <= max_d;
            lock_q       <= lock_d;
            lock_cnt_q   <= lock_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign out_of_tol = oot_q;
    assign min_period = min_q;
    assign max_period = max_q;
    assign lock       = lock_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Testbench for clk_freq_monitor: edge-index reference model checked every cycle,
// a table of periodic waveforms, and hand-written timeout/enable/reset sequences.
module tb_clk_freq_monitor;

    localparam int TIMEOUT = 1000;
    localparam int LOCKN   = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, clear, sig_in;
    logic [15:0] exp_period, tol;
    logic [15:0] period, high_time, min_period, max_period;
    logic        meas_valid, out_of_tol, lock, timeout;

    clk_freq_monitor #(.CNT_W(16), .LOCK_CNT(LOCKN), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .sig_in(sig_in),
        .exp_period(exp_period), .tol(tol), .period(period), .high_time(high_time),
        .meas_valid(meas_valid), .out_of_tol(out_of_tol), .min_period(min_period),
        .max_period(max_period), .lock(lock), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int mv_count = 0;
    bit rnd_clear = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Reference model in terms of clk-edge indices: a sampled 0->1 at edge e is
    // acted on at edge e+3; a period is the distance between two such edges.
    bit samp[64];
    int k = 8;
    int md_mode = 0;               // 0 off, 1 waiting for first rise, 2 measuring
    int last_k = 0, fall_k = 0;
    bit fseen = 0;
    int m_period = 0, m_high = 0, m_min = 65535, m_max = 0, m_lcnt = 0;
    bit m_mv = 0, m_oot = 0, m_lock = 0, m_to = 0;

    always @(posedge clk) begin
        bit r, f;
        int p, d;
        if (!rst_n) begin
            for (int j = 0; j < 64; j++) samp[j] = 1'b0;
            md_mode = 0; m_period = 0; m_high = 0; m_mv = 0; m_oot = 0;
            m_min = 65535; m_max = 0; m_lock = 0; m_lcnt = 0; m_to = 0; fseen = 0;
        end else begin
            k++;
            samp[k % 64] = sig_in;
            r = samp[(k - 3) % 64] && !samp[(k - 4) % 64];
            f = !samp[(k - 3) % 64] && samp[(k - 4) % 64];
            m_mv = 0;
            if (!en) begin
                md_mode = 0;
            end else if (md_mode == 0) begin
                md_mode = 1;
            end else if (md_mode == 1) begin
                if (r) begin md_mode = 2; last_k = k; fseen = 0; end
            end else begin
                if (f) begin fseen = 1; fall_k = k; end
                if (r) begin
                    p = k - last_k;
                    m_mv = 1;
                    m_period = p;
                    m_high = fseen ? (fall_k - last_k) : p;
                    d = p - int'(exp_period);
                    if (d < 0) d = -d;
                    m_oot = (d > int'(tol));
                    if (m_oot) begin m_lcnt = 0; m_lock = 0; end
                    else begin
                        if (m_lcnt < LOCKN) m_lcnt++;
                        m_lock = (m_lcnt == LOCKN);
                    end
                    if (p < m_min) m_min = p;
                    if (p > m_max) m_max = p;
                    last_k = k; fseen = 0;
                end else if (k - last_k == TIMEOUT) begin
                    m_to = 1; m_lock = 0; m_lcnt = 0; md_mode = 1;
                end
            end
            if (clear) begin m_min = 65535; m_max = 0; m_lock = 0; m_lcnt = 0; m_to = 0; end
        end
        #1;
        chk("mdl_meas_valid", meas_valid, m_mv);
        chk("mdl_period", period, m_period);
        chk("mdl_high_time", high_time, m_high);
        chk("mdl_out_of_tol", out_of_tol, m_oot);
        chk("mdl_min", min_period, m_min);
        chk("mdl_max", max_period, m_max);
        chk("mdl_lock", lock, m_lock);
        chk("mdl_timeout", timeout, m_to);
    end

    always @(negedge clk) if (meas_valid === 1'b1) mv_count++;

    task automatic wave(input int n, input int h, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                sig_in = (c < h);
                clear = rnd_clear && ($urandom_range(0, 39) == 0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            sig_in = 1'b0;
        end
    endtask

    typedef struct {
        int n, h, expp, tl, reps;
        int e_per, e_high, e_oot, e_lock;
    } vec_t;
    vec_t tv[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, mv_base, n, h;
        tv[0] = '{n:10, h:3, expp:10, tl:0, reps:6, e_per:10, e_high:3, e_oot:0, e_lock:1};
        tv[1] = '{n:13, h:5, expp:10, tl:2, reps:2, e_per:13, e_high:5, e_oot:1, e_lock:0};
        tv[2] = '{n:12, h:4, expp:10, tl:2, reps:5, e_per:12, e_high:4, e_oot:0, e_lock:1};
        tv[3] = '{n:8,  h:2, expp:10, tl:2, reps:3, e_per:8,  e_high:2, e_oot:0, e_lock:0};
        tv[4] = '{n:20, h:1, expp:20, tl:0, reps:3, e_per:20, e_high:1, e_oot:0, e_lock:0};

        rst_n = 1'b0; en = 1'b0; clear = 1'b0; sig_in = 1'b0;
        exp_period = 16'd10; tol = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_period", period, 0);
        chk("reset_min", min_period, 16'hFFFF);
        chk("reset_max", max_period, 0);
        chk("reset_meas_valid", meas_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        idle(3);

        for (int i = 0; i < 5; i++) begin
            exp_period = 16'(tv[i].expp);
            tol = 16'(tv[i].tl);
            wave(tv[i].n, tv[i].h, tv[i].reps);
            idle(4);
            chk($sformatf("vec%0d_period", i), period, tv[i].e_per);
            chk($sformatf("vec%0d_high", i), high_time, tv[i].e_high);
            chk($sformatf("vec%0d_oot", i), out_of_tol, tv[i].e_oot);
            chk($sformatf("vec%0d_lock", i), lock, tv[i].e_lock);
        end
        chk("minmax_min", min_period, 8);
        chk("minmax_max", max_period, 20);

        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("clear_min", min_period, 16'hFFFF);
        chk("clear_max", max_period, 0);
        chk("clear_lock", lock, 0);

        // Relock, then hold low until the timeout fires
        exp_period = 16'd10; tol = 16'd0;
        wave(10, 3, 5);
        @(negedge clk); sig_in = 1'b1;
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) sig_in = 1'b0;
            if (i == TIMEOUT + 3) begin
                chk("to_before_timeout", timeout, 0);
                chk("to_before_lock", lock, 1);
            end
            if (i == TIMEOUT + 4) begin
                chk("to_timeout", timeout, 1);
                chk("to_lock", lock, 0);
            end
        end

        mv_base = mv_count;
        wave(10, 3, 1);
        @(negedge clk); sig_in = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (meas_valid === 1'b1 && lat == 0) lat = i;
            if (i == 3) sig_in = 1'b0;
        end
        @(negedge clk);
        chk("restart_latency", lat, 4);
        chk("restart_meas_count", mv_count - mv_base, 1);
        chk("restart_period", period, 10);
        chk("restart_timeout_sticky", timeout, 1);

        // Enable dropped mid-period, then re-raised
        wave(10, 3, 3);
        @(negedge clk); en = 1'b0;
        idle(6);
        en = 1'b1;
        idle(2);
        mv_base = mv_count;
        wave(10, 3, 1);
        idle(4);
        chk("en_no_meas", mv_count - mv_base, 0);
        chk("en_hold_period", period, 10);
        chk("en_hold_high", high_time, 3);
        wave(6, 2, 1);
        idle(6);
        chk("en_meas_count", mv_count - mv_base, 1);
        chk("en_period", period, 14);
        chk("en_high", high_time, 3);

        // Asynchronous reset between clock edges
        wave(10, 3, 2);
        @(negedge clk); sig_in = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("areset_period", period, 0);
        chk("areset_high", high_time, 0);
        chk("areset_min", min_period, 16'hFFFF);
        chk("areset_max", max_period, 0);
        chk("areset_lock", lock, 0);
        chk("areset_timeout", timeout, 0);
        chk("areset_meas_valid", meas_valid, 0);
        sig_in = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        mv_base = mv_count;
        wave(10, 3, 3);
        idle(5);
        chk("areset_meas_count", mv_count - mv_base, 2);
        chk("areset_new_period", period, 10);

        // Randomized waveforms, clears and enable drops against the model
        rnd_clear = 1'b1;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); en = 1'b0; clear = 1'b0;
                idle(int'($urandom_range(1, 5)));
                en = 1'b1;
            end
            exp_period = 16'($urandom_range(4, 24));
            tol = 16'($urandom_range(0, 3));
            n = int'($urandom_range(2, 30));
            h = int'($urandom_range(1, n - 1));
            wave(n, h, int'($urandom_range(1, 4)));
        end
        rnd_clear = 1'b0;
        @(negedge clk); clear = 1'b0;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
